player_ctrl_param: RTL and testbench
====================================

Name: player_ctrl_param

Overview:
- Parametrised next-generation player controller for the Space Invaders datapath.
- Converts the raw joystick code into rate-limited, bounds-saturated horizontal motion.
- Issues fire requests to the bullet block over a valid/ready handshake with a cooldown.
- Handles hit/respawn; feeds Player_Row/Player_Col to the renderer and collision logic.

Parameters:
- ROW_W, 9, width of Player_Row
- COL_W, 10, width of Player_Col and Shot_col
- JOY_W, 4, width of Joystick_data
- JOY_CENTER, 5, joystick neutral code
- JOY_DEAD, 1, dead-band half-width around JOY_CENTER
- ROW_POS, 440, fixed player row
- COL_MIN, 8, leftmost legal column
- COL_MAX, 600, rightmost legal column
- START_COL, 304, column after reset and respawn
- STEP, 2, columns moved per move tick
- MOVE_DIV, 250000, clocks per move tick (>=2)
- SHOT_OFFSET, 16, added to Player_Col to form Shot_col
- COOLDOWN, 5000000, clocks between shots (>=1)
- RESPAWN, 100000000, clocks spent dead (>=1)
- ACCEL_TICKS, 32, consecutive same-direction ticks before speed-up (PLAYER_ACCEL_EN only)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous reset, active-low
- Enable  in  1  game running; low = paused
- Joystick_data  in  JOY_W  raw horizontal joystick code
- Fire_btn  in  1  fire button level (already synchronised)
- Player_Hit  in  1  one-cycle hit pulse from collision logic
- Shot_ready  in  1  bullet block can accept a shot
- Player_Row  out  ROW_W  player row
- Player_Col  out  COL_W  player column
- Player_Alive  out  1  high when alive
- Shot_valid  out  1  shot request pending
- Shot_col  out  COL_W  shot spawn column, stable while Shot_valid

Behaviour:
- Reset (Reset==0 at Clk edge): Player_Col=START_COL, Player_Row=ROW_POS (constant), Player_Alive=1, Shot_valid=0, Shot_col=0, FSM=IDLE, all counters 0, Fire_btn edge register=0.
- Divider: counts 0..MOVE_DIV-1 while Enable && Alive, otherwise holds. A move tick occurs on the edge where count==MOVE_DIV-1; the count then wraps to 0.
- Direction is sampled on the tick:
  - Joystick_data > JOY_CENTER+JOY_DEAD → right.
  - Joystick_data < JOY_CENTER-JOY_DEAD → left.
  - Otherwise neutral.
- Player_Col updates on the tick edge and is visible the next cycle.
- Saturation, computed at COL_W+1 bits:
  - Right: col+step > COL_MAX → COL_MAX.
  - Left: col < COL_MIN+step → COL_MIN.
  - No wrap-around.
- Fire FSM states: IDLE, REQ, COOL, DEAD.
  - IDLE: a Fire_btn rising edge (Fire_btn && !Fire_btn_d) with Enable → REQ. Shot_col latches Player_Col+SHOT_OFFSET (truncated to COL_W) and Shot_valid=1 on the next cycle.
  - REQ: Shot_valid held and Shot_col stable until Shot_ready is sampled high. That edge completes the transfer; → COOL, Shot_valid=0.
  - COOL: counts COOLDOWN cycles, then → IDLE.
  - Fire edges arriving in REQ or COOL are dropped, not queued.
  - DEAD: Player_Alive=0, Shot_valid=0, position held, divider frozen. After RESPAWN cycles: Player_Col=START_COL, Alive=1, → IDLE.
- Player_Hit in IDLE, REQ or COOL → DEAD on the same edge; any pending request is abandoned.
- Player_Hit in DEAD is ignored; the respawn timer is not restarted.
- Player_Hit and Shot_ready both high in REQ: the transfer counts (valid&ready that cycle), then → DEAD.
- Enable low: no motion and no new fire requests. An in-flight REQ handshake, COOL and DEAD keep running.
- Reset asserted in any state overrides everything, including mid-handshake.

Optional Feature:
- PLAYER_ACCEL_EN defined: a hold counter increments on each move tick with the same non-neutral direction as the previous tick.
  - Neutral, a direction reversal, entry to DEAD or reset clears it.
  - Once the counter reaches ACCEL_TICKS, step=2*STEP; saturation rules are unchanged.
- Undefined: step is always STEP, no hold counter is built, and ACCEL_TICKS is ignored.

Test Plan (overrides: MOVE_DIV=4, STEP=2, COL_MIN=0, COL_MAX=20, START_COL=10, SHOT_OFFSET=1, COOLDOWN=3, RESPAWN=8, ACCEL_TICKS=2):
- Reset=0 for 5 cycles, Joystick_data=5 → Col=10, Row=ROW_POS, Alive=1, Shot_valid=0. Hold 5 for 40 cycles → Col stays 10.
- Joystick_data=7 for 24 cycles → Col 12,14,...,20 at 4-cycle spacing, then stays 20. Joystick_data=3 for 48 cycles → stays at 0, never wraps. Codes 4/6 → no motion.
- Fire rising edge with Shot_ready=0 → Shot_valid=1, Shot_col=Col+1, held. Raise Shot_ready → valid drops next cycle. Second edge within 3 cycles → ignored. Edge after the cooldown → new request.
- Player_Hit during REQ → Shot_valid=0, Alive=0 next cycle, joystick=7 causes no motion. After 8 cycles → Col=10, Alive=1. A second hit while dead → respawn timing unchanged.
- Enable=0 with joystick=7 and a fire edge → no motion, no request. Reset=0 mid-REQ → all outputs return to reset values.
- PLAYER_ACCEL_EN: joystick=7 from Col=0 → 2,4,8,12; then 5 for one tick, then 7 → step back to 2.

Source files
------------

// File: rtl/player_ctrl_param.sv
// =============================================================================
// player_ctrl_param
// -----------------------------------------------------------------------------
// Player controller for the Space Invaders datapath.
//
// Turns the raw joystick code into rate-limited, edge-saturated horizontal
// motion, issues fire requests to the bullet block over a valid/ready
// handshake with a cooldown, and runs the hit / respawn sequence.
//
// Optional build macro:
//   PLAYER_ACCEL_EN  - when defined, a hold counter tracks consecutive move
//                      ticks in the same direction; once it reaches
//                      ACCEL_TICKS the step doubles. When undefined, the step
//                      is always STEP and no hold counter exists.
//
// Ports:
//   Clk            in   system clock
//   Reset          in   synchronous reset, active-low
//   Enable         in   game running; low = paused (no motion, no new shots)
//   Joystick_data  in   raw horizontal joystick code [JOY_W]
//   Fire_btn       in   fire button level, already synchronised
//   Player_Hit     in   one-cycle hit pulse from collision logic
//   Shot_ready     in   bullet block can accept a shot
//   Player_Row     out  fixed player row [ROW_W]
//   Player_Col     out  player column [COL_W]
//   Player_Alive   out  high while the player is alive
//   Shot_valid     out  shot request pending
//   Shot_col       out  shot spawn column, stable while Shot_valid [COL_W]
// =============================================================================
module player_ctrl_param #(
   parameter int ROW_W       = 9,
   parameter int COL_W       = 10,
   parameter int JOY_W       = 4,
   parameter int JOY_CENTER  = 5,
   parameter int JOY_DEAD    = 1,
   parameter int ROW_POS     = 440,
   parameter int COL_MIN     = 8,
   parameter int COL_MAX     = 600,
   parameter int START_COL   = 304,
   parameter int STEP        = 2,
   parameter int MOVE_DIV    = 250000,
   parameter int SHOT_OFFSET = 16,
   parameter int COOLDOWN    = 5000000,
   parameter int RESPAWN     = 100000000,
   parameter int ACCEL_TICKS = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [JOY_W-1:0] Joystick_data,
   input  logic             Fire_btn,
   input  logic             Player_Hit,
   input  logic             Shot_ready,
   output logic [ROW_W-1:0] Player_Row,
   output logic [COL_W-1:0] Player_Col,
   output logic             Player_Alive,
   output logic             Shot_valid,
   output logic [COL_W-1:0] Shot_col
);

   // ------------------------------------------------------------------------
   // Elaboration-time sanity check on the timing parameters.
   // ------------------------------------------------------------------------
   if (MOVE_DIV < 2 || COOLDOWN < 1 || RESPAWN < 1 || ACCEL_TICKS < 1) begin : g_param_check
      $error("player_ctrl_param: MOVE_DIV must be >= 2, COOLDOWN, RESPAWN and ACCEL_TICKS >= 1");
   end

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int DIV_W   = $clog2(MOVE_DIV);
   localparam int TMR_MAX = (COOLDOWN > RESPAWN) ? COOLDOWN : RESPAWN;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   // Column arithmetic is done one bit wider so right moves cannot wrap.
   localparam int CW1     = COL_W + 1;
   localparam int JOY_HI  = JOY_CENTER + JOY_DEAD;
   localparam int JOY_LO  = JOY_CENTER - JOY_DEAD;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(MOVE_DIV - 1);
   localparam logic [TMR_W-1:0] COOL_LAST  = TMR_W'(COOLDOWN - 1);
   localparam logic [TMR_W-1:0] RESP_LAST  = TMR_W'(RESPAWN - 1);
   localparam logic [CW1-1:0]   COL_MIN_X  = CW1'(COL_MIN);
   localparam logic [CW1-1:0]   COL_MAX_X  = CW1'(COL_MAX);
   localparam logic [COL_W-1:0] COL_MIN_C  = COL_W'(COL_MIN);
   localparam logic [COL_W-1:0] COL_MAX_C  = COL_W'(COL_MAX);
   localparam logic [COL_W-1:0] START_C    = COL_W'(START_COL);
   localparam logic [COL_W-1:0] OFFSET_C   = COL_W'(SHOT_OFFSET);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_COOL,
      ST_DEAD
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   // ------------------------------------------------------------------------
   // Registers and wires
   // ------------------------------------------------------------------------
   state_t             r_state;
   state_t             w_state_next;
   logic [DIV_W-1:0]   r_div_cnt;
   logic [TMR_W-1:0]   r_timer;
   logic [COL_W-1:0]   r_col;
   logic [COL_W-1:0]   r_shot_col;
   logic               r_fire_d;

   logic               w_alive;
   logic               w_run;
   logic               w_tick;
   logic               w_fire_rise;
   logic               w_load_shot;
   logic               w_respawn;
   int                 w_joy_val;
   dir_t               w_dir;
   logic [CW1-1:0]     w_step;
   logic [CW1-1:0]     w_col_ext;
   logic [CW1-1:0]     w_col_right;
   logic [CW1-1:0]     w_col_left;
   logic [COL_W-1:0]   w_col_move;

   assign w_alive     = (r_state != ST_DEAD);
   // The divider only runs while the game is live; pausing or dying freezes it.
   assign w_run       = Enable && w_alive;
   assign w_tick      = w_run && (r_div_cnt == DIV_LAST);
   assign w_fire_rise = Fire_btn && !r_fire_d;
   assign w_respawn   = (r_state == ST_DEAD) && (r_timer == RESP_LAST);

   // ------------------------------------------------------------------------
   // Joystick decode: codes inside the dead band around JOY_CENTER are neutral.
   // ------------------------------------------------------------------------
   assign w_joy_val = int'(Joystick_data);

   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned; that is what keeps latches from being inferred.
      w_dir = DIR_NONE;
      if (w_joy_val > JOY_HI) begin
         w_dir = DIR_RIGHT;
      end else if (w_joy_val < JOY_LO) begin
         w_dir = DIR_LEFT;
      end
   end

   // ------------------------------------------------------------------------
   // Step size (optionally accelerated)
   // ------------------------------------------------------------------------
`ifdef PLAYER_ACCEL_EN
   localparam int              HOLD_W   = $clog2(ACCEL_TICKS + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(ACCEL_TICKS);

   logic [HOLD_W-1:0] r_hold_cnt;
   dir_t              r_last_dir;
   logic [HOLD_W-1:0] w_hold_next;

   // The step is chosen from the count this tick will produce, so the tick
   // that reaches ACCEL_TICKS already moves at double speed.
   always_comb begin
      w_hold_next = '0;
      if ((w_dir != DIR_NONE) && (w_dir == r_last_dir)) begin
         w_hold_next = (r_hold_cnt == HOLD_LIM) ? r_hold_cnt : r_hold_cnt + 1'b1;
      end
   end

   assign w_step = (w_hold_next >= HOLD_LIM) ? CW1'(2 * STEP) : CW1'(STEP);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_hold_cnt <= '0;
         r_last_dir <= DIR_NONE;
      end else if ((w_state_next == ST_DEAD) && (r_state != ST_DEAD)) begin
         r_hold_cnt <= '0;
      end else if (w_tick) begin
         r_hold_cnt <= w_hold_next;
         r_last_dir <= w_dir;
      end
   end
`else
   assign w_step = CW1'(STEP);
`endif

   // ------------------------------------------------------------------------
   // Saturating column update
   // ------------------------------------------------------------------------
   assign w_col_ext   = {1'b0, r_col};
   assign w_col_right = w_col_ext + w_step;
   assign w_col_left  = w_col_ext - w_step;

   always_comb begin
      w_col_move = r_col;
      case (w_dir)
         DIR_RIGHT: begin
            if (w_col_right > COL_MAX_X) begin
               w_col_move = COL_MAX_C;
            end else begin
               w_col_move = w_col_right[COL_W-1:0];
            end
         end
         DIR_LEFT: begin
            // Compare before subtracting so a small column never underflows.
            if (w_col_ext < COL_MIN_X + w_step) begin
               w_col_move = COL_MIN_C;
            end else begin
               w_col_move = w_col_left[COL_W-1:0];
            end
         end
         default: w_col_move = r_col;
      endcase
   end

   // ------------------------------------------------------------------------
   // Move divider and column register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!Reset) begin
         r_div_cnt <= '0;
      end else if (w_run) begin
         r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_col <= START_C;
      end else if (w_respawn) begin
         r_col <= START_C;
      end else if (w_tick) begin
         r_col <= w_col_move;
      end
   end

   // ------------------------------------------------------------------------
   // Fire / life FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Fire / life FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_load_shot  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Player_Hit) begin
               w_state_next = ST_DEAD;
            end else if (w_fire_rise && Enable) begin
               w_state_next = ST_REQ;
               w_load_shot  = 1'b1;
            end
         end
         ST_REQ: begin
            // A hit together with Shot_ready still completes the transfer
            // (valid and ready are both high); the player then dies.
            if (Player_Hit) begin
               w_state_next = ST_DEAD;
            end else if (Shot_ready) begin
               w_state_next = ST_COOL;
            end
         end
         ST_COOL: begin
            if (Player_Hit) begin
               w_state_next = ST_DEAD;
            end else if (r_timer == COOL_LAST) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_DEAD: begin
            // Further hits are ignored so the respawn timer is never restarted.
            if (r_timer == RESP_LAST) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Shared cooldown / respawn timer: restarts at 0 on every state change and
   // counts only in COOL and DEAD.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_timer <= '0;
      end else if (w_state_next != r_state) begin
         r_timer <= '0;
      end else if ((r_state == ST_COOL) || (r_state == ST_DEAD)) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Fire edge detect and shot column capture
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_fire_d   <= 1'b0;
         r_shot_col <= '0;
      end else begin
         r_fire_d <= Fire_btn;
         if (w_load_shot) begin
            // Wraps at COL_W bits by design.
            r_shot_col <= r_col + OFFSET_C;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign Player_Row   = ROW_W'(ROW_POS);
   assign Player_Col   = r_col;
   assign Player_Alive = w_alive;
   assign Shot_valid   = (r_state == ST_REQ);
   assign Shot_col     = r_shot_col;

endmodule

// File: tb/tb_player_ctrl_param.sv
// =============================================================================
// tb_player_ctrl_param
// -----------------------------------------------------------------------------
// Self-checking bench for player_ctrl_param with small timing parameters.
// Directed vector table, a few hand-written multi-cycle sequences, then
// randomized stimulus compared every cycle against a behavioural model.
// Honours PLAYER_ACCEL_EN when the build defines it.
// =============================================================================
module tb_player_ctrl_param;

   localparam int ROW_W       = 9;
   localparam int COL_W       = 10;
   localparam int JOY_W       = 4;
   localparam int JOY_CENTER  = 5;
   localparam int JOY_DEAD    = 1;
   localparam int ROW_POS     = 440;
   localparam int COL_MIN     = 0;
   localparam int COL_MAX     = 20;
   localparam int START_COL   = 10;
   localparam int STEP        = 2;
   localparam int MOVE_DIV    = 4;
   localparam int SHOT_OFFSET = 1;
   localparam int COOLDOWN    = 3;
   localparam int RESPAWN     = 8;
   localparam int ACCEL_TICKS = 2;

   logic             Clk;
   logic             Reset;
   logic             Enable;
   logic [JOY_W-1:0] Joystick_data;
   logic             Fire_btn;
   logic             Player_Hit;
   logic             Shot_ready;
   logic [ROW_W-1:0] Player_Row;
   logic [COL_W-1:0] Player_Col;
   logic             Player_Alive;
   logic             Shot_valid;
   logic [COL_W-1:0] Shot_col;

   player_ctrl_param #(
      .ROW_W(ROW_W), .COL_W(COL_W), .JOY_W(JOY_W), .JOY_CENTER(JOY_CENTER),
      .JOY_DEAD(JOY_DEAD), .ROW_POS(ROW_POS), .COL_MIN(COL_MIN), .COL_MAX(COL_MAX),
      .START_COL(START_COL), .STEP(STEP), .MOVE_DIV(MOVE_DIV),
      .SHOT_OFFSET(SHOT_OFFSET), .COOLDOWN(COOLDOWN), .RESPAWN(RESPAWN),
      .ACCEL_TICKS(ACCEL_TICKS)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Enable(Enable), .Joystick_data(Joystick_data),
      .Fire_btn(Fire_btn), .Player_Hit(Player_Hit), .Shot_ready(Shot_ready),
      .Player_Row(Player_Row), .Player_Col(Player_Col), .Player_Alive(Player_Alive),
      .Shot_valid(Shot_valid), .Shot_col(Shot_col)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: countdowns and min/max arithmetic over plain ints.
   // ------------------------------------------------------------------------
   int m_col, m_run, m_cool_left, m_dead_left, m_hold, m_prev_dir, m_shot;
   bit m_alive, m_valid, m_fire_prev;

   task automatic model_update();
      bit rise;
      int dir, step, old_col, joy;
      if (!Reset) begin
         m_col = START_COL; m_alive = 1; m_valid = 0; m_shot = 0; m_run = 0;
         m_fire_prev = 0; m_cool_left = 0; m_dead_left = 0; m_hold = 0; m_prev_dir = 0;
         return;
      end
      rise = Fire_btn && !m_fire_prev;
      m_fire_prev = Fire_btn;
      if (!m_alive) begin
         m_dead_left--;
         if (m_dead_left == 0) begin
            m_alive = 1;
            m_col   = START_COL;
         end
         return;
      end
      old_col = m_col;
      if (Enable) begin
         if (m_run % MOVE_DIV == MOVE_DIV - 1) begin
            joy = int'(Joystick_data);
            dir = (joy > JOY_CENTER + JOY_DEAD) ? 1 : (joy < JOY_CENTER - JOY_DEAD) ? -1 : 0;
            step = STEP;
`ifdef PLAYER_ACCEL_EN
            if (dir != 0 && dir == m_prev_dir)
               m_hold = (m_hold + 1 > ACCEL_TICKS) ? ACCEL_TICKS : m_hold + 1;
            else
               m_hold = 0;
            m_prev_dir = dir;
            if (m_hold >= ACCEL_TICKS) step = 2 * STEP;
`endif
            if (dir > 0)      m_col = (m_col + step > COL_MAX) ? COL_MAX : m_col + step;
            else if (dir < 0) m_col = (m_col - step < COL_MIN) ? COL_MIN : m_col - step;
         end
         m_run++;
      end
      if (Player_Hit) begin
         m_alive = 0; m_valid = 0; m_cool_left = 0; m_dead_left = RESPAWN; m_hold = 0;
         return;
      end
      if (m_valid) begin
         if (Shot_ready) begin
            m_valid     = 0;
            m_cool_left = COOLDOWN;
         end
      end else if (m_cool_left > 0) begin
         m_cool_left--;
      end else if (rise && Enable) begin
         m_valid = 1;
         m_shot  = (old_col + SHOT_OFFSET) % (1 << COL_W);
      end
   endtask

   // Advance n clock edges, keeping the model in step, and stop 1 time unit
   // after the last edge so outputs are sampled away from the edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge Clk);
         model_update();
      end
      #1;
   endtask

   task automatic drive(input bit rst, input bit en, input int joy, input bit fire,
                        input bit hit, input bit ready);
      Reset = rst; Enable = en; Joystick_data = JOY_W'(joy);
      Fire_btn = fire; Player_Hit = hit; Shot_ready = ready;
   endtask

   // ------------------------------------------------------------------------
   // Directed vector table
   // ------------------------------------------------------------------------
   typedef struct {
      bit rst_n; bit en; int joy; bit fire; bit hit; bit ready;
      int cycles;
      int exp_col; bit exp_alive; bit exp_valid; int exp_shot;  // exp_shot < 0: don't care
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, input bit en, input int joy, input bit fire,
                      input bit hit, input bit ready, input int cycles,
                      input int col, input bit alive, input bit valid, input int shot);
      vec_t v;
      v.rst_n = rst; v.en = en; v.joy = joy; v.fire = fire; v.hit = hit; v.ready = ready;
      v.cycles = cycles; v.exp_col = col; v.exp_alive = alive; v.exp_valid = valid;
      v.exp_shot = shot;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(0, 1, 5, 0, 0, 0);

      //   rst en joy f  h  r  cyc col al v  shot
      add(0, 1, 5, 0, 0, 0,  5, 10, 1, 0, 0);    // reset values
      add(1, 1, 5, 0, 0, 0, 40, 10, 1, 0, -1);   // neutral: no drift
      add(1, 1, 7, 0, 0, 0,  4, 12, 1, 0, -1);   // right, one tick every 4 clocks
      add(1, 1, 7, 0, 0, 0,  4, 14, 1, 0, -1);
`ifdef PLAYER_ACCEL_EN
      add(1, 1, 7, 0, 0, 0,  4, 18, 1, 0, -1);
      add(1, 1, 7, 0, 0, 0,  4, 20, 1, 0, -1);
`else
      add(1, 1, 7, 0, 0, 0,  4, 16, 1, 0, -1);
      add(1, 1, 7, 0, 0, 0,  4, 18, 1, 0, -1);
`endif
      add(1, 1, 7, 0, 0, 0,  4, 20, 1, 0, -1);   // reaches COL_MAX
      add(1, 1, 7, 0, 0, 0,  4, 20, 1, 0, -1);   // saturated
      add(1, 1, 3, 0, 0, 0,  4, 18, 1, 0, -1);   // left
      add(1, 1, 3, 0, 0, 0, 44,  0, 1, 0, -1);   // saturates at COL_MIN, no wrap
      add(1, 1, 7, 0, 0, 0,  4,  2, 1, 0, -1);
      add(1, 1, 4, 0, 0, 0,  8,  2, 1, 0, -1);   // dead-band codes
      add(1, 1, 6, 0, 0, 0,  8,  2, 1, 0, -1);
      add(1, 1, 5, 1, 0, 0,  1,  2, 1, 1, 3);    // fire edge -> request
      add(1, 1, 5, 1, 0, 0,  3,  2, 1, 1, 3);    // held while not ready
      add(1, 1, 5, 1, 0, 1,  1,  2, 1, 0, -1);   // handshake completes
      add(1, 1, 5, 0, 0, 0,  1,  2, 1, 0, -1);
      add(1, 1, 5, 1, 0, 0,  1,  2, 1, 0, -1);   // edge during cooldown dropped
      add(1, 1, 5, 0, 0, 0,  2,  2, 1, 0, -1);
      add(1, 1, 5, 1, 0, 0,  1,  2, 1, 1, 3);    // edge after cooldown accepted
      add(1, 1, 5, 1, 1, 0,  1,  2, 0, 0, -1);   // hit mid-request
      add(1, 1, 7, 0, 0, 0,  3,  2, 0, 0, -1);   // dead: no motion
      add(1, 1, 7, 0, 1, 0,  1,  2, 0, 0, -1);   // hit while dead ignored
      add(1, 1, 7, 0, 0, 0,  3,  2, 0, 0, -1);
      add(1, 1, 7, 0, 0, 0,  1, 10, 1, 0, -1);   // respawn after 8 clocks
      add(1, 0, 7, 1, 0, 0,  4, 10, 1, 0, -1);   // paused: no motion, no shot
      add(1, 1, 5, 0, 0, 0,  1, 10, 1, 0, -1);
      add(1, 1, 5, 1, 0, 0,  1, 10, 1, 1, 11);
      add(0, 1, 5, 1, 0, 0,  1, 10, 1, 0, 0);    // reset mid-request
`ifdef PLAYER_ACCEL_EN
      add(1, 1, 3, 0, 0, 0,  4,  8, 1, 0, -1);
      add(1, 1, 3, 0, 0, 0,  4,  6, 1, 0, -1);
      add(1, 1, 3, 0, 0, 0,  4,  2, 1, 0, -1);
      add(1, 1, 3, 0, 0, 0,  4,  0, 1, 0, -1);
      add(1, 1, 7, 0, 0, 0,  4,  2, 1, 0, -1);
      add(1, 1, 7, 0, 0, 0,  4,  4, 1, 0, -1);
      add(1, 1, 7, 0, 0, 0,  4,  8, 1, 0, -1);
      add(1, 1, 7, 0, 0, 0,  4, 12, 1, 0, -1);
      add(1, 1, 5, 0, 0, 0,  4, 12, 1, 0, -1);
      add(1, 1, 7, 0, 0, 0,  4, 14, 1, 0, -1);   // acceleration cleared by neutral
`endif

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].joy, vecs[i].fire, vecs[i].hit, vecs[i].ready);
         cyc(vecs[i].cycles);
         check($sformatf("vec%0d col", i),   Player_Col,   vecs[i].exp_col);
         check($sformatf("vec%0d row", i),   Player_Row,   ROW_POS);
         check($sformatf("vec%0d alive", i), Player_Alive, vecs[i].exp_alive);
         check($sformatf("vec%0d valid", i), Shot_valid,   vecs[i].exp_valid);
         if (vecs[i].exp_shot >= 0)
            check($sformatf("vec%0d shot_col", i), Shot_col, vecs[i].exp_shot);
      end

      // ---------------------------------------------------------------------
      // Hand-written: handshake and cooldown keep running while paused, and
      // a hit together with Shot_ready still ends the request.
      // ---------------------------------------------------------------------
      drive(0, 1, 5, 0, 0, 0); cyc(1);
      drive(1, 1, 5, 0, 0, 0); cyc(1);
      drive(1, 1, 5, 1, 0, 0); cyc(1);
      check("seq req valid", Shot_valid, 1);
      check("seq req col",   Shot_col,   11);
      drive(1, 0, 5, 1, 0, 0); cyc(2);
      check("seq paused valid held", Shot_valid, 1);
      drive(1, 0, 5, 1, 0, 1); cyc(1);
      check("seq paused handshake", Shot_valid, 0);
      drive(1, 0, 5, 0, 0, 0); cyc(3);
      drive(1, 1, 5, 1, 0, 0); cyc(1);
      check("seq cooldown ran while paused", Shot_valid, 1);
      drive(1, 1, 5, 1, 1, 1); cyc(1);
      check("seq hit+ready valid", Shot_valid,   0);
      check("seq hit+ready alive", Player_Alive, 0);
      drive(1, 1, 5, 0, 0, 0); cyc(7);
      check("seq still dead", Player_Alive, 0);
      cyc(1);
      check("seq respawn alive", Player_Alive, 1);
      check("seq respawn col",   Player_Col,   START_COL);

      // ---------------------------------------------------------------------
      // Randomized stimulus against the model
      // ---------------------------------------------------------------------
      drive(0, 1, 5, 0, 0, 0); cyc(1);
      for (int n = 0; n < 3000; n++) begin
         Reset  = ($urandom_range(0, 299) != 0);
         Enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) Joystick_data = JOY_W'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) Fire_btn = !Fire_btn;
         Player_Hit = ($urandom_range(0, 49) == 0);
         Shot_ready = ($urandom_range(0, 2) == 0);
         cyc(1);
         check("rnd col",   Player_Col,   m_col);
         check("rnd row",   Player_Row,   ROW_POS);
         check("rnd alive", Player_Alive, m_alive);
         check("rnd valid", Shot_valid,   m_valid);
         if (m_valid) check("rnd shot_col", Shot_col, m_shot);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
